serial_pattern_tx: RTL and testbench

Serial bit-stream transmitter that drives the single-bit `x` input of the 101 sequence detectors (Mealy/Moore, overlapping).
- Loads a parallel word and shifts it out LSB-first, one bit per clock.
- Tracks in parallel how many overlapping "101" occurrences it has emitted, giving a cycle-exact expected count to score against detector `y` pulses.
- Replaces hand-coded bit loops in detector benches and doubles as a synthesizable on-board stimulus source.

---
 rtl/serial_pattern_tx.sv | 156 +++++++++++++++
 tb/tb_serial_pattern_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Serial LSB-first word transmitter with a running count of overlapping "101" matches.
// Define PATTERN_LOOP_EN to repeat the latched word continuously until stop or reset.
module serial_pattern_tx #(
   parameter int   WIDTH    = 20,
   parameter int   CNT_W    = 5,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             stop,
   input  logic [WIDTH-1:0] data,
   input  logic [CNT_W-1:0] len,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   bit_cnt, bit_cnt_next;
   logic [CNT_W-1:0]   len_q, len_q_next;
   logic [WIDTH-1:0]   shreg, shreg_next;
   logic [1:0]         hist, hist_next;
   logic               x_next, x_valid_next, busy_next, done_next;
   logic [CNT_W-1:0]   match_next;
   logic [CNT_W-1:0]   eff_len;
`ifdef PATTERN_LOOP_EN
   logic [WIDTH-1:0]   data_q, data_q_next;
`endif

   assign eff_len = (len == '0 || len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : len;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         len_q     <= '0;
         shreg     <= '0;
         hist      <= 2'b00;
         x         <= IDLE_BIT;
         x_valid   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         match_cnt <= '0;
`ifdef PATTERN_LOOP_EN
         data_q    <= '0;
`endif
      end else begin
         state     <= state_next;
         bit_cnt   <= bit_cnt_next;
         len_q     <= len_q_next;
         shreg     <= shreg_next;
         hist      <= hist_next;
         x         <= x_next;
         x_valid   <= x_valid_next;
         busy      <= busy_next;
         done      <= done_next;
         match_cnt <= match_next;
`ifdef PATTERN_LOOP_EN
         data_q    <= data_q_next;
`endif
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (load) state_next = SHIFT;
         SHIFT: begin
            if (stop) state_next = IDLE;
`ifndef PATTERN_LOOP_EN
            else if (bit_cnt == len_q) state_next = IDLE;
`endif
         end
      endcase
   end

   // Every path that places a new stream bit on x funnels through emit, so the
   // match history is updated in exactly one place.
   always_comb begin
      logic             emit;
      logic             new_bit;
      logic [1:0]       hist_base;
      logic [CNT_W-1:0] match_base;

      emit         = 1'b0;
      new_bit      = 1'b0;
      hist_base    = hist;
      match_base   = match_cnt;
      bit_cnt_next = bit_cnt;
      len_q_next   = len_q;
      shreg_next   = shreg;
      hist_next    = hist;
      match_next   = match_cnt;
      x_next       = IDLE_BIT;
      x_valid_next = 1'b0;
      busy_next    = 1'b0;
      done_next    = 1'b0;
`ifdef PATTERN_LOOP_EN
      data_q_next  = data_q;
`endif

      case (state)
         IDLE: begin
            if (load) begin
               shreg_next   = data;
               len_q_next   = eff_len;
               bit_cnt_next = CNT_W'(1);
               new_bit      = data[0];
               hist_base    = 2'b00;
               match_base   = '0;
               emit         = 1'b1;
`ifdef PATTERN_LOOP_EN
               data_q_next  = data;
`endif
            end
         end
         SHIFT: begin
            if (stop) begin
               bit_cnt_next = '0;
            end else if (bit_cnt == len_q) begin
               done_next    = 1'b1;
`ifdef PATTERN_LOOP_EN
               shreg_next   = data_q;
               bit_cnt_next = CNT_W'(1);
               new_bit      = data_q[0];
               emit         = 1'b1;
`else
               bit_cnt_next = '0;
`endif
            end else begin
               shreg_next   = shreg >> 1;
               new_bit      = shreg[1];
               bit_cnt_next = bit_cnt + CNT_W'(1);
               emit         = 1'b1;
            end
         end
      endcase

      // hist holds {previous bit, bit before it}; 2'b01 followed by a 1 completes "101".
      if (emit) begin
         x_next       = new_bit;
         x_valid_next = 1'b1;
         busy_next    = 1'b1;
         hist_next    = {new_bit, hist_base[1]};
         match_next   = match_base;
         if (hist_base == 2'b01 && new_bit && match_base != '1)
            match_next = match_base + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: a stream-level model compared every cycle,
// plus literal expectations for latency, bit order and match counts.
module tb_serial_pattern_tx;

   localparam int W = 20;
   localparam logic [19:0] WORD1 = 20'b10100010100101010100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load, stop;
   logic [19:0] data;
   logic [4:0]  len;
   logic        x, x_valid, busy, done;
   logic [4:0]  match_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int e0       = 0;
   int lat;
   int pd;
   bit check_en = 1'b0;

   int          cap_n = 0;
   logic [19:0] capv  = '0;
   int          done_pulses = 0;

   // Model: the word, its length, which bit is on x, and every bit sent since the last load.
   logic [19:0] m_word   = '0;
   int          m_len    = 0;
   int          m_pos    = 0;
   bit          m_active = 1'b0;
   bit          m_done   = 1'b0;
   bit          m_stream[$];

   serial_pattern_tx #(.WIDTH(W), .CNT_W(5), .IDLE_BIT(1'b0)) dut (
      .clk(clk), .rst(rst), .load(load), .stop(stop), .data(data), .len(len),
      .x(x), .x_valid(x_valid), .busy(busy), .done(done), .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int count101();
      int c = 0;
      for (int i = 2; i < m_stream.size(); i++)
         if (m_stream[i-2] && !m_stream[i-1] && m_stream[i]) c++;
      return (c > 31) ? 31 : c;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_stream.delete();
      end else begin
         m_done = 1'b0;
         if (!m_active) begin
            if (load) begin
               m_word   = data;
               m_len    = (len == 0 || len > W) ? W : int'(len);
               m_pos    = 0;
               m_active = 1'b1;
               m_stream.delete();
               m_stream.push_back(data[0]);
            end
         end else if (stop) begin
            m_active = 1'b0;
         end else if (m_pos == m_len - 1) begin
            m_done = 1'b1;
`ifdef PATTERN_LOOP_EN
            m_pos = 0;
            m_stream.push_back(m_word[0]);
`else
            m_active = 1'b0;
`endif
         end else begin
            m_pos++;
            m_stream.push_back(m_word[m_pos]);
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         check_output("x",         x,         m_active ? int'(m_word[m_pos]) : 0);
         check_output("x_valid",   x_valid,   m_active);
         check_output("busy",      busy,      m_active);
         check_output("done",      done,      m_done);
         check_output("match_cnt", match_cnt, count101());
         if (x_valid && cap_n < 20) begin
            capv[cap_n] = x;
            cap_n++;
         end
         if (done) done_pulses++;
      end
   end

   task automatic apply_stimulus(input logic [19:0] d, input logic [4:0] l);
      @(negedge clk);
      data = d;
      len  = l;
      load = 1'b1;
      @(posedge clk);
      #1;
      e0    = cyc;
      load  = 1'b0;
      cap_n = 0;
      capv  = '0;
      data  = 20'($urandom);
      len   = 5'($urandom);
   endtask

   task automatic wait_done(input int max_cyc, output int lat_o);
      bit seen = 1'b0;
      lat_o = -1;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen  = 1'b1;
            lat_o = cyc - e0;
         end
      end
      if (!seen) check_output("done_timeout", 0, 1);
   endtask

   initial begin
      load = 1'b0; stop = 1'b0; data = '0; len = '0;
      #1 rst = 1'b0;
      #2;
      check_output("rst_x", x, 0);
      check_output("rst_x_valid", x_valid, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      check_output("rst_match", match_cnt, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      check_en = 1'b1;

      // Full 20-bit word with five overlapping matches
      apply_stimulus(WORD1, 5'd20);
      wait_done(40, lat);
      check_output("s1_latency", lat, 20);
      check_output("s1_match", match_cnt, 5);
      check_output("s1_nbits", cap_n, 20);
      check_output("s1_bits", capv, 20'b10100010100101010100);

      // Short word, load while busy ignored, then load on the done cycle accepted
      apply_stimulus(20'b101, 5'd3);
      @(negedge clk);
      load = 1'b1; data = 20'h00000; len = 5'd20;
      @(negedge clk);
      load = 1'b0;
      wait_done(10, lat);
      check_output("s2_latency", lat, 3);
      check_output("s2_match", match_cnt, 1);
      check_output("s2_nbits", cap_n, 3);
      check_output("s2_bits", capv[2:0], 3'b101);
      data = 20'h00005; len = 5'd4; load = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc; load = 1'b0; cap_n = 0; capv = '0;
      check_output("s2b_busy", busy, 1);
      wait_done(10, lat);
      check_output("s2b_latency", lat, 4);
      check_output("s2b_match", match_cnt, 1);

      // len = 0 means full width
      apply_stimulus(20'hFFFFF, 5'd0);
      wait_done(40, lat);
      check_output("s3_latency", lat, 20);
      check_output("s3_match", match_cnt, 0);
      check_output("s3_bits", capv, 20'hFFFFF);

      // Single bit, and len beyond WIDTH clamps to WIDTH
      apply_stimulus(20'h00001, 5'd1);
      wait_done(10, lat);
      check_output("s4_latency", lat, 1);
      check_output("s4_nbits", cap_n, 1);
      apply_stimulus(20'h00005, 5'd25);
      wait_done(40, lat);
      check_output("s4b_latency", lat, 20);
      check_output("s4b_match", match_cnt, 1);

      // Stop while bit 7 is on x
      apply_stimulus(WORD1, 5'd20);
      repeat (7) @(posedge clk);
      @(negedge clk);
      stop = 1'b1;
      pd = done_pulses;
      @(posedge clk);
      #1 stop = 1'b0;
      @(negedge clk);
      check_output("stop_x", x, 0);
      check_output("stop_busy", busy, 0);
      check_output("stop_match", match_cnt, 2);
      repeat (5) @(negedge clk);
      check_output("stop_no_done", done_pulses, pd);

      // Load and stop together in idle: load wins
      @(negedge clk);
      data = 20'b101; len = 5'd3; load = 1'b1; stop = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc; load = 1'b0; stop = 1'b0; cap_n = 0; capv = '0;
      check_output("ls_busy", busy, 1);
      wait_done(10, lat);
      check_output("ls_latency", lat, 3);

      // Asynchronous reset between edges mid-stream
      apply_stimulus(WORD1, 5'd20);
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check_output("arst_x", x, 0);
      check_output("arst_x_valid", x_valid, 0);
      check_output("arst_busy", busy, 0);
      check_output("arst_done", done, 0);
      check_output("arst_match", match_cnt, 0);
      pd = done_pulses;
      @(negedge clk);
      rst = 1'b1;
      repeat (25) @(negedge clk);
      check_output("arst_no_done", done_pulses, pd);

`ifdef PATTERN_LOOP_EN
      // Continuous 1,0 pattern: matches cross pass boundaries and saturate at 31
      pd = done_pulses;
      apply_stimulus(20'b01, 5'd2);
      repeat (80) @(negedge clk);
      check_output("loop_match", match_cnt, 31);
      check_output("loop_done_pulses", done_pulses - pd, 39);
      stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      @(negedge clk);
      check_output("loop_stop_busy", busy, 0);
`endif

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
